// File: rtl/inert_pkg.sv
// Shared types and SPI command words for the inertial-sensor sequencer.
// The state enum encodes configuration, idle and read-burst phases.
package inert_pkg;

    typedef enum logic [3:0] {
        PWRUP, CFG0, CFG1, CFG2, IDLE, RD0, RD1, RD2, RD3, VLD
    } inert_state_t;

    localparam logic [15:0] CMD_INT_CFG  = 16'h0D02;
    localparam logic [15:0] CMD_GYRO_CFG = 16'h1160;
    localparam logic [15:0] CMD_RND_CFG  = 16'h1460;
    localparam logic [15:0] CMD_YAWL     = 16'hA600;
    localparam logic [15:0] CMD_YAWH     = 16'hA700;
    localparam logic [15:0] CMD_PITCHL   = 16'hA200;
    localparam logic [15:0] CMD_PITCHH   = 16'hA300;

    // Command word issued on entry to each transfer state.
    function automatic logic [15:0] cmd_for(input inert_state_t s);
        case (s)
            CFG0:    return CMD_INT_CFG;
            CFG1:    return CMD_GYRO_CFG;
            CFG2:    return CMD_RND_CFG;
            RD0:     return CMD_YAWL;
            RD1:     return CMD_YAWH;
            RD2:     return CMD_PITCHL;
            RD3:     return CMD_PITCHH;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/inert_seq_if.sv
// Handshake between the sequencer (master) and the SPI monarch (slave).
interface inert_seq_if;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, wt_data, input done, rd_data);
    modport slave  (input wrt, wt_data, output done, rd_data);
endinterface

// File: rtl/inert_seq_int_sync.sv
// Two-flop synchroniser for the sensor interrupt plus a one-cycle rising-edge pulse.
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], async_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/inert_seq.sv
// Power-up configuration and interrupt-driven yaw (and, with INERT_PITCH_EN, pitch) reads
// over the SPI monarch; assembled rates are presented with a one-cycle vld strobe.
module inert_seq
    import inert_pkg::*;
#(
    parameter int PWRUP_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    inert_seq_if.master spi,
    output logic [15:0] yaw_rt,
    output logic        vld
`ifdef INERT_PITCH_EN
    ,
    output logic [15:0] pitch_rt
`endif
);

`ifdef INERT_PITCH_EN
    localparam inert_state_t LAST_RD = RD3;
`else
    localparam inert_state_t LAST_RD = RD1;
`endif

    inert_state_t        state_q, state_d;
    logic                wait_q, wait_d;
    logic [PWRUP_W-1:0]  cnt_q, cnt_d;
    logic                int_pend_q, int_pend_d;
    logic                wrt_q, wrt_d;
    logic [15:0]         wt_data_q, wt_data_d;
    logic                vld_q, vld_d;
    logic [15:0]         yaw_rt_q, yaw_rt_d;
    logic [7:0]          yaw_l_q, yaw_l_d;
`ifdef INERT_PITCH_EN
    logic [7:0]          yaw_h_q, yaw_h_d;
    logic [7:0]          pitch_l_q, pitch_l_d;
    logic [15:0]         pitch_rt_q, pitch_rt_d;
`endif
    logic                int_rise;
    logic                launch;
    logic [7:0]          rd_byte;
    logic                unused_rd_hi;

    int_sync u_int_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (INT),
        .rise_o  (int_rise)
    );

    assign rd_byte      = spi.rd_data[7:0];
    assign unused_rd_hi = ^spi.rd_data[15:8];

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cnt_d      = cnt_q;
        int_pend_d = int_pend_q | int_rise;
        wrt_d      = 1'b0;
        wt_data_d  = wt_data_q;
        vld_d      = 1'b0;
        yaw_rt_d   = yaw_rt_q;
        yaw_l_d    = yaw_l_q;
        launch     = 1'b0;
`ifdef INERT_PITCH_EN
        yaw_h_d    = yaw_h_q;
        pitch_l_d  = pitch_l_q;
        pitch_rt_d = pitch_rt_q;
`endif
        unique case (state_q)
            PWRUP: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = CFG0;
                    launch  = 1'b1;
                end
            end
            IDLE: begin
                // An edge arriving on the consuming cycle stays pending for another burst.
                if (int_pend_q) begin
                    int_pend_d = int_rise;
                    state_d    = RD0;
                    launch     = 1'b1;
                end
            end
            VLD: state_d = IDLE;
            default: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (spi.done) begin
                    wait_d = 1'b0;
                    case (state_q)
                        RD0:     yaw_l_d   = rd_byte;
`ifdef INERT_PITCH_EN
                        RD1:     yaw_h_d   = rd_byte;
                        RD2:     pitch_l_d = rd_byte;
`endif
                        default: ;
                    endcase
                    if (state_q == LAST_RD) begin
                        // Final byte bypasses its holding register so vld lands one clock after done.
                        state_d = VLD;
                        vld_d   = 1'b1;
`ifdef INERT_PITCH_EN
                        yaw_rt_d   = {yaw_h_q, yaw_l_q};
                        pitch_rt_d = {rd_byte, pitch_l_q};
`else
                        yaw_rt_d   = {rd_byte, yaw_l_q};
`endif
                    end else begin
                        state_d = inert_state_t'(state_q + 4'd1);
                        launch  = (state_d != IDLE);
                    end
                end
            end
        endcase

        if (launch) begin
            wrt_d     = 1'b1;
            wt_data_d = cmd_for(state_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PWRUP;
            wait_q     <= 1'b0;
            cnt_q      <= '0;
            int_pend_q <= 1'b0;
            wrt_q      <= 1'b0;
            wt_data_q  <= 16'h0000;
            vld_q      <= 1'b0;
            yaw_rt_q   <= 16'h0000;
            yaw_l_q    <= 8'h00;
`ifdef INERT_PITCH_EN
            yaw_h_q    <= 8'h00;
            pitch_l_q  <= 8'h00;
            pitch_rt_q <= 16'h0000;
`endif
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            cnt_q      <= cnt_d;
            int_pend_q <= int_pend_d;
            wrt_q      <= wrt_d;
            wt_data_q  <= wt_data_d;
            vld_q      <= vld_d;
            yaw_rt_q   <= yaw_rt_d;
            yaw_l_q    <= yaw_l_d;
`ifdef INERT_PITCH_EN
            yaw_h_q    <= yaw_h_d;
            pitch_l_q  <= pitch_l_d;
            pitch_rt_q <= pitch_rt_d;
`endif
        end
    end

    assign spi.wrt     = wrt_q;
    assign spi.wt_data = wt_data_q;
    assign yaw_rt      = yaw_rt_q;
    assign vld         = vld_q;
`ifdef INERT_PITCH_EN
    assign pitch_rt    = pitch_rt_q;
`endif

endmodule

// File: tb/tb_inert_seq.sv
// Bench for inert_seq: SPI monarch model answering from an expected-transaction queue,
// plus a per-cycle compare of wrt/wt_data/vld/yaw_rt against the expected sequence.
module tb_inert_seq;
    import inert_pkg::*;

    localparam int PW  = 4;
    localparam int LAT = 5;
`ifdef INERT_PITCH_EN
    localparam logic [15:0] LAST_CMD = CMD_PITCHH;
`else
    localparam logic [15:0] LAST_CMD = CMD_YAWH;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic int_in = 1'b0;
    always #10 clk = ~clk;

    inert_seq_if spi ();
    logic [15:0] yaw_rt;
    logic        vld;
`ifdef INERT_PITCH_EN
    logic [15:0] pitch_rt;
`endif

    inert_seq #(.PWRUP_W(PW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .INT    (int_in),
        .spi    (spi),
        .yaw_rt (yaw_rt),
        .vld    (vld)
`ifdef INERT_PITCH_EN
        ,
        .pitch_rt (pitch_rt)
`endif
    );

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  resp;
    } xfer_t;

    xfer_t       exp_q[$];
    xfer_t       x;
    int          total = 0;
    int          bad = 0;
    int          cyc;
    int          first_wrt_cyc = -1;
    int          wrt_cnt = 0;
    int          vld_cnt = 0;
    int          last_vld_cyc = -100;
    int          burst_gap = -1;
    int          lat_cnt = 0;
    bit          busy = 0;
    bit          done_fresh = 0;
    bit          prev_wrt = 0;
    bit          exp_vld;
    bit          exp_follow;
    logic [15:0] cur_cmd = 16'h0000;
    logic [7:0]  cur_resp = 8'h00;
    logic [7:0]  m_yl = 0, m_yh = 0, m_pl = 0, m_ph = 0;
    logic [15:0] m_yaw = 0, m_pitch = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Monarch model and per-cycle compare.
    always @(negedge clk) begin
        if (!rst_n) begin
            spi.done      = 1'b0;
            spi.rd_data   = 16'h0000;
            busy          = 0;
            done_fresh    = 0;
            prev_wrt      = 0;
            cur_cmd       = 16'h0000;
            m_yaw         = 16'h0000;
            m_pitch       = 16'h0000;
            first_wrt_cyc = -1;
            wrt_cnt       = 0;
        end else begin
            exp_vld    = done_fresh && (cur_cmd == LAST_CMD);
            exp_follow = done_fresh && (cur_cmd != LAST_CMD) && (cur_cmd != CMD_RND_CFG);
            if (exp_vld) begin
                m_yaw   = {m_yh, m_yl};
                m_pitch = {m_ph, m_pl};
            end
            check("vld", vld, exp_vld);
            check("yaw_rt", yaw_rt, m_yaw);
`ifdef INERT_PITCH_EN
            check("pitch_rt", pitch_rt, m_pitch);
`endif
            if (vld) begin
                vld_cnt++;
                last_vld_cyc = cyc;
            end
            if (done_fresh) check("wrt_after_done", spi.wrt, exp_follow);
            if (busy && !spi.wrt) check("wt_data_hold", spi.wt_data, cur_cmd);
            if (spi.wrt) begin
                wrt_cnt++;
                if (first_wrt_cyc < 0) first_wrt_cyc = cyc;
                check("wrt_one_cycle", prev_wrt, 0);
                check("wrt_while_busy", busy, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_wrt: got wt_data=%h, expected no transaction", spi.wt_data);
                end else begin
                    x = exp_q.pop_front();
                    check("wt_data", spi.wt_data, x.cmd);
                    if (x.cmd != CMD_INT_CFG && x.cmd != CMD_YAWL)
                        check("wrt_needs_done", done_fresh, 1);
                    if (x.cmd == CMD_YAWL) burst_gap = cyc - last_vld_cyc;
                    cur_cmd  = x.cmd;
                    cur_resp = x.resp;
                    busy     = 1;
                    lat_cnt  = LAT;
                    spi.done = 1'b0;
                end
            end
            prev_wrt   = spi.wrt;
            done_fresh = 0;
            if (busy) begin
                if (lat_cnt == 0) begin
                    spi.done    = 1'b1;
                    spi.rd_data = {8'hA5, cur_resp};
                    busy        = 0;
                    done_fresh  = 1;
                    case (cur_cmd)
                        CMD_YAWL:   m_yl = cur_resp;
                        CMD_YAWH:   m_yh = cur_resp;
                        CMD_PITCHL: m_pl = cur_resp;
                        CMD_PITCHH: m_ph = cur_resp;
                        default: ;
                    endcase
                end else begin
                    lat_cnt--;
                end
            end
        end
    end

    task automatic load_cfg();
        exp_q.delete();
        exp_q.push_back('{CMD_INT_CFG, 8'h00});
        exp_q.push_back('{CMD_GYRO_CFG, 8'h00});
        exp_q.push_back('{CMD_RND_CFG, 8'h00});
    endtask

    task automatic burst(input logic [7:0] yl, input logic [7:0] yh,
                         input logic [7:0] pl, input logic [7:0] ph);
        exp_q.push_back('{CMD_YAWL, yl});
        exp_q.push_back('{CMD_YAWH, yh});
`ifdef INERT_PITCH_EN
        exp_q.push_back('{CMD_PITCHL, pl});
        exp_q.push_back('{CMD_PITCHH, ph});
`else
        if (pl == ph) exp_q = exp_q; // pitch bytes are unused without the pitch build
`endif
    endtask

    task automatic pulse_int();
        @(negedge clk);
        #2 int_in = 1'b1;
        repeat (2) @(negedge clk);
        #2 int_in = 1'b0;
    endtask

    task automatic wait_wrt(input logic [15:0] cmd, input string name, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(spi.wrt && spi.wt_data == cmd) && n < 100);
        check({name, "_seen"}, (spi.wrt && spi.wt_data == cmd), 1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, (n < 400), 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wrt"}, spi.wrt, 0);
        check({tag, "_wt_data"}, spi.wt_data, 16'h0000);
        check({tag, "_yaw_rt"}, yaw_rt, 16'h0000);
        check({tag, "_vld"}, vld, 0);
`ifdef INERT_PITCH_EN
        check({tag, "_pitch_rt"}, pitch_rt, 16'h0000);
`endif
    endtask

    initial begin
        int n;
        load_cfg();
        repeat (3) @(negedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk);
        #5 rst_n = 1'b1;

        // Power-up: first wrt at clock 16, three configuration writes.
        drain("cfg");
        check("first_wrt_cyc", first_wrt_cyc, 16);
        check("cfg_wrt_count", wrt_cnt, 3);

        // Yaw read 0x1234 (pitch 0xBEEF); INT rise to wrt takes 4 clocks.
        burst(8'h34, 8'h12, 8'hEF, 8'hBE);
        @(negedge clk);
        #2 int_in = 1'b1;
        wait_wrt(CMD_YAWL, "yaw_start", n);
        int_in = 1'b0;
        check("int_to_wrt", n, 4);
        drain("yaw");
        check("yaw_vld_count", vld_cnt, 1);
        check("yaw_1234", yaw_rt, 16'h1234);
`ifdef INERT_PITCH_EN
        check("pitch_beef", pitch_rt, 16'hBEEF);
`endif

        // Negative rate holds across idle cycles.
        burst(8'h00, 8'hFF, 8'h00, 8'h80);
        pulse_int();
        drain("neg");
        repeat (10) @(negedge clk);
        check("neg_vld_count", vld_cnt, 2);
        check("yaw_ff00_hold", yaw_rt, 16'hFF00);

        // INT edge during RD1: second burst right after VLD plus one IDLE cycle.
        burst(8'h11, 8'h22, 8'h01, 8'h02);
        burst(8'h33, 8'h44, 8'h03, 8'h04);
        pulse_int();
        wait_wrt(CMD_YAWH, "b2b_rd1", n);
        pulse_int();
        drain("b2b");
        check("b2b_vld_count", vld_cnt, 4);
        check("b2b_gap", burst_gap, 2);
        check("b2b_yaw", yaw_rt, 16'h4433);

        // Three edges during one burst collapse into exactly one extra burst.
        burst(8'h55, 8'h66, 8'h05, 8'h06);
        burst(8'h77, 8'h88, 8'h07, 8'h08);
        pulse_int();
        wait_wrt(CMD_YAWL, "tri_start", n);
        repeat (3) pulse_int();
        drain("tri");
        repeat (40) @(negedge clk);
        check("tri_vld_count", vld_cnt, 6);
        check("tri_queue_empty", exp_q.size(), 0);
        check("tri_yaw", yaw_rt, 16'h8877);

        // Reset during the RD0 wait phase.
        burst(8'h9A, 8'hBC, 8'h09, 8'h0A);
        pulse_int();
        wait_wrt(CMD_YAWL, "rst_rd0", n);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b0;
        load_cfg();
        #1 check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        #5 rst_n = 1'b1;
        drain("recfg");
        check("recfg_first_wrt_cyc", first_wrt_cyc, 16);
        check("recfg_wrt_count", wrt_cnt, 3);
        check("recfg_yaw", yaw_rt, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/inert_seq.md
# inert_seq

Transaction sequencer for the inertial-sensor SPI link. It sits between the SPI monarch and the integration logic. After power-up it writes the sensor configuration. On each sensor data-ready interrupt it reads the yaw-rate registers, assembles the 16-bit rate and presents it with a one-cycle valid strobe. It is the only issuer of `wrt` to the SPI monarch.

## Interface
- `PWRUP_W`, default 16: width of the power-up delay counter; the delay is 2^`PWRUP_W` clocks.
- `clk` input, 1 bit: system clock, 50 MHz.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `INT` input, 1 bit: sensor data-ready interrupt. Asynchronous, active-high.
- `done` input, 1 bit: SPI monarch transaction-complete flag. Held high until the next `wrt`.
- `rd_data` input, 16 bits: SPI monarch read word. Only [7:0] is meaningful for register reads.
- `wrt` output, 1 bit: one-cycle pulse that starts an SPI transaction.
- `wt_data` output, 16 bits: command word. Registered, and stable from `wrt` until `done`.
- `yaw_rt` output, 16 bits: signed yaw rate, {high byte, low byte}.
- `vld` output, 1 bit: one-cycle strobe; `yaw_rt` (and `pitch_rt`) are new.
- `pitch_rt` output, 16 bits: present only when `INERT_PITCH_EN` is defined.

## Operation
- **States:** PWRUP, CFG0, CFG1, CFG2, IDLE, RD0…RDn, VLD. Each CFG or RD state has a pulse phase (`wrt`=1 for one clock) and a wait phase (hold until `done`=1).
- **PWRUP:** the free-running counter increments from 0. When it reaches all-ones, the block moves to CFG0.
- **CFG0/1/2:** write 0x0D02 (INT enable on data-ready), then 0x1160 (gyro 416 Hz, 250 dps), then 0x1460 (rounding). After CFG2 the block moves to IDLE.
- **INT synchronisation:** two-flop synchroniser, then rising-edge detect. A detected edge sets `int_pend`.
- **IDLE:** if `int_pend`=1, clear it and enter RD0.
- **Yaw reads:**
  - RD0 sends 0xA600 (yawL) and captures `rd_data[7:0]` into the low holding register on `done`.
  - RD1 sends 0xA700 (yawH) and captures into the high holding register.
- **VLD:** load `yaw_rt` ← {yawH, yawL}, pulse `vld`, return to IDLE.
- **Handshake rules:**
  - `wrt` is asserted only in the pulse phase.
  - The wait phase is entered on the cycle after `wrt`. The monarch has cleared `done` on that same edge, so any `done`=1 seen in the wait phase belongs to the current transaction.
  - `wt_data` is loaded in the same cycle `wrt` asserts.
- **Overlapping interrupts:** an INT edge arriving during RD/VLD sets `int_pend`, and the next burst starts right after IDLE. Multiple edges during one burst collapse to one pending burst; they do not queue.
- **Reset mid-transaction:** everything returns to PWRUP with the counter at 0. The full configuration is reissued.

## Timing
- **Reset values:**
  - `wrt`=0, `wt_data`=0x0000, `yaw_rt`=0x0000, `pitch_rt`=0x0000, `vld`=0.
  - state = PWRUP, counter = 0, `int_pend`=0, synchroniser flops = 0.
- **First `wrt`:** one clock after the counter reaches 2^`PWRUP_W`−1.
- **INT to `wrt`:** INT rise to the internal edge takes 3 clocks; `wrt` follows 1 clock later when IDLE.
- **`done` to next `wrt`:** the next `wrt` follows `done` in the wait phase by exactly 1 clock.
- **Output update:** `vld` is high exactly 1 clock after the final read's `done`. `yaw_rt` updates on the same edge and holds until the next VLD.

## Configuration
- **`INERT_PITCH_EN` defined:** the read burst is RD0..RD3.
  - Adds 0xA200 (pitchL) and 0xA300 (pitchH) after the yaw reads.
  - The `pitch_rt` port and its holding registers exist.
  - `pitch_rt` and `yaw_rt` update together at VLD.
- **`INERT_PITCH_EN` undefined:** the burst is RD0..RD1 only; there is no `pitch_rt` port or pitch registers.

## Structure
- **Package `inert_pkg`:** state enum `inert_state_t` and command constants `CMD_INT_CFG`, `CMD_GYRO_CFG`, `CMD_RND_CFG`, `CMD_YAWL`, `CMD_YAWH`, `CMD_PITCHL`, `CMD_PITCHH`.
- **Sub-module `int_sync`:** two-flop synchroniser plus rising-edge pulse, reset to 0.

## Test plan
- **Power-up:** `PWRUP_W`=4 → first `wrt` at clock 16 with `wt_data`=0x0D02, then 0x1160, then 0x1460. Each follows a `done`, and each `wrt` is exactly one cycle long.
- **Yaw read:** INT pulse in IDLE; serf model returns 0x34 for 0xA600 and 0x12 for 0xA700 → `vld` 1 clock after the second `done`, `yaw_rt`=0x1234.
- **Negative rate:** returns 0x00 then 0xFF → `yaw_rt`=0xFF00; `yaw_rt` holds across the following idle cycles.
- **Back-to-back interrupts:** INT edge during RD1 → second burst starts immediately after VLD. Three edges during one burst → exactly one extra burst.
- **Reset during RD0:** `rst_n` low during RD0 wait → outputs at reset values immediately; the configuration sequence is reissued after the delay.
- **`INERT_PITCH_EN`:** four reads in order A6, A7, A2, A3 → `pitch_rt`=0xBEEF and `yaw_rt` update in the same `vld` cycle.
